fc_output_layer: RTL and testbench
==================================

Name: fc_output_layer

Overview:
- Final fully-connected stage of the OCR datapath.
- Computes OUT_SIZE signed 32-bit logits: for each neuron j, logit[j] = bias[j] + sum over i of x[i]*W[j][i].
- Reads its operands from three external synchronous ROM/RAM ports (inputs, weights, biases) and stores the logits in an internal score buffer.
- Exposes the score buffer through an addr/data read port and a size output, which the downstream argmax classifier consumes; `done` serves as argmax's start pulse.

Parameters:
- IN_SIZE, 784, number of input activations per neuron (max 65535).
- OUT_SIZE, 10, number of neurons/logits (max 16).
- RELU, 0, 1 = clamp negative logits to 0 before storing; 0 = store raw.

Ports:
- clk  input  1  clock, all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to compute all logits; ignored while busy.
- in_addr  output  16  input-activation memory address.
- in_data  input  8  signed activation, valid 1 cycle after in_addr.
- w_addr  output  16  weight memory address, = j*IN_SIZE + i (row-major).
- w_data  input  8  signed weight, valid 1 cycle after w_addr.
- b_addr  output  4  bias memory address (= j).
- b_data  input  32  signed bias, valid 1 cycle after b_addr.
- rd_addr  input  16  score buffer read address (driven by argmax).
- rd_data  output  32  signed logit at rd_addr; combinational.
- out_size  output  16  constant OUT_SIZE.
- busy  output  1  high while computing.
- done  output  1  one-cycle pulse when all logits are written.

Behaviour:
- Reset (asynchronous) forces:
  - state IDLE; busy=0, done=0.
  - in_addr=0, w_addr=0, b_addr=0.
  - all score entries = 0.
  - accumulator = 0, pipeline valid = 0.
- Reset mid-operation aborts the run. No partial results survive.
- States:
  - IDLE: start=1 → RUN, with j=0, i=0, w_addr=0, busy=1.
  - RUN (one cycle per i): drive in_addr=i, w_addr=j*IN_SIZE+i, b_addr=j. The MAC for the previous address, if valid, happens in the same cycle. When i=IN_SIZE-1, go to DRAIN.
  - DRAIN: perform the final MAC; go to STORE.
  - STORE:
    - Saturate the accumulator, apply RELU, write score[j].
    - If j=OUT_SIZE-1: go to IDLE, busy<=0, done<=1.
    - Otherwise: j++, i=0, go to RUN.
- MAC arithmetic:
  - product = in_data*w_data, signed 16-bit.
  - Accumulator is 48-bit signed; products are sign-extended.
  - First MAC of each neuron: acc <= sext(b_data) + product (bias loaded, no separate cycle).
  - Later MACs: acc <= acc + product.
- Saturation at STORE:
  - acc > 2^31-1 → 32'h7FFFFFFF.
  - acc < -2^31 → 32'h80000000.
  - Otherwise the low 32 bits.
  - RELU=1 then maps negative results to 0.
- Latency: start sampled at edge E → done high during the cycle after edge E + OUT_SIZE*(IN_SIZE+2). busy is high over the same span.
- done: exactly one cycle wide.
- start while busy: ignored, no restart. start in the same cycle as done-pulse state (IDLE): accepted.
- Addresses hold their last value in IDLE.
- Read port:
  - rd_data = score[rd_addr] if rd_addr < OUT_SIZE, else 0.
  - Reads during a run return the current contents: new values for written neurons, old values otherwise.
  - A write and a read of the same entry in the same cycle return the old value; the new value is visible next cycle.

Test Plan:
All scenarios use IN_SIZE=4, OUT_SIZE=3, memories with 1-cycle read latency unless stated.
- Basic:
  - Stimulus: x=[1,2,3,4]; W rows [1,1,1,1], [-1,0,0,0], [2,2,2,2]; b=[10,0,-5]; pulse start.
  - Response: done exactly 18 cycles after start edge; scores [20,-1,15]; out_size=3.
  - Argmax chained on done yields max_index=0.
- Saturation:
  - Stimulus: x all -128, W row0 all -128, b0=32'h7FFFF000 → response score0=32'h7FFFFFFF.
  - Stimulus: x all 127, W row1 all -128, b1=32'h80000000 → response score1=32'h80000000.
- RELU=1 with the Basic stimulus → scores [20,0,15].
- Start during busy:
  - Stimulus: pulse start again at cycle 5.
  - Response: done still at cycle 18, single pulse; results identical to Basic.
- Reset mid-run:
  - Stimulus: assert reset at cycle 7.
  - Response: immediately busy=0, done=0, rd_data=0 for addr 0..2.
  - Stimulus: release reset, pulse start.
  - Response: Basic results after 18 cycles.
- Read port:
  - Stimulus: rd_addr=3 and rd_addr=16'hFFFF → response rd_data=0.
  - Stimulus: poll rd_addr=0 during run → response changes 0→20 the cycle after neuron 0 STORE (cycle 6).

Source files
------------

// File: rtl/fc_output_layer.sv
// rtl/fc_output_layer.sv - final fully-connected layer producing signed 32-bit logits
//
// Computes logit[j] = bias[j] + sum_i x[i]*W[j][i] for OUT_SIZE neurons,
// saturates to 32 bits (optionally clamps negatives when RELU=1) and keeps
// the results in an internal score buffer read by the argmax stage.
//
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   start             one-cycle compute request, ignored while busy
//   in_addr/in_data   activation memory port (data 1 cycle after addr)
//   w_addr/w_data     weight memory port, row-major j*IN_SIZE+i
//   b_addr/b_data     bias memory port, addr = neuron index
//   rd_addr/rd_data   combinational score buffer read port
//   out_size          constant OUT_SIZE
//   busy, done        run in progress / one-cycle completion pulse
module fc_output_layer #(
  parameter int IN_SIZE  = 784,
  parameter int OUT_SIZE = 10,
  parameter int RELU     = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [15:0] in_addr,
  input  logic [7:0]  in_data,
  output logic [15:0] w_addr,
  input  logic [7:0]  w_data,
  output logic [3:0]  b_addr,
  input  logic [31:0] b_data,
  input  logic [15:0] rd_addr,
  output logic [31:0] rd_data,
  output logic [15:0] out_size,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_STORE} state_t;

  localparam logic [15:0] I_LAST = 16'(IN_SIZE - 1);
  localparam logic [3:0]  J_LAST = 4'(OUT_SIZE - 1);
  localparam logic signed [47:0] ACC_MAX = 48'sd2147483647;
  localparam logic signed [47:0] ACC_MIN = -48'sd2147483648;

  state_t             state;
  logic [15:0]        i_cnt;
  logic               mac_valid;   // memory data this cycle belongs to a live address
  logic               mac_first;   // that address was i=0, so fold in the bias
  logic signed [47:0] acc;
  logic signed [31:0] score [OUT_SIZE];

  logic signed [15:0] in_ext;
  logic signed [15:0] w_ext;
  logic signed [15:0] product;
  logic signed [47:0] mac_base;
  logic signed [47:0] mac_next;
  logic [31:0]        sat_val;
  logic [31:0]        store_val;

  assign out_size = 16'(OUT_SIZE);

  // 8x8 signed product always fits in 16 bits, so a 16-bit multiply is exact.
  assign in_ext   = {{8{in_data[7]}}, in_data};
  assign w_ext    = {{8{w_data[7]}}, w_data};
  assign product  = in_ext * w_ext;
  assign mac_base = mac_first ? {{16{b_data[31]}}, b_data} : acc;
  assign mac_next = mac_base + {{32{product[15]}}, product};

  always_comb begin
    sat_val = acc[31:0];
    if (acc > ACC_MAX)
      sat_val = 32'h7FFF_FFFF;
    else if (acc < ACC_MIN)
      sat_val = 32'h8000_0000;
    store_val = sat_val;
    if (RELU != 0 && sat_val[31])
      store_val = 32'h0;
  end

  always_comb begin
    rd_data = 32'h0;
    for (int k = 0; k < OUT_SIZE; k++)
      if (rd_addr == 16'(k))
        rd_data = score[k];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      in_addr   <= '0;
      w_addr    <= '0;
      b_addr    <= '0;
      i_cnt     <= '0;
      mac_valid <= 1'b0;
      mac_first <= 1'b0;
      acc       <= '0;
      for (int k = 0; k < OUT_SIZE; k++)
        score[k] <= '0;
    end else begin
      done <= 1'b0;
      if (mac_valid)
        acc <= mac_next;
      case (state)
        S_IDLE: begin
          mac_valid <= 1'b0;
          if (start) begin
            state   <= S_RUN;
            busy    <= 1'b1;
            i_cnt   <= '0;
            in_addr <= '0;
            w_addr  <= '0;
            b_addr  <= '0;
          end
        end
        S_RUN: begin
          mac_valid <= 1'b1;
          mac_first <= (i_cnt == 16'h0);
          if (i_cnt == I_LAST) begin
            state <= S_DRAIN;
          end else begin
            i_cnt   <= i_cnt + 16'h1;
            in_addr <= i_cnt + 16'h1;
            w_addr  <= w_addr + 16'h1;
          end
        end
        S_DRAIN: begin
          mac_valid <= 1'b0;
          state     <= S_STORE;
        end
        S_STORE: begin
          for (int k = 0; k < OUT_SIZE; k++)
            if (b_addr == 4'(k))
              score[k] <= store_val;
          if (b_addr == J_LAST) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            // Next row starts right after the previous one in row-major order.
            state   <= S_RUN;
            b_addr  <= b_addr + 4'h1;
            i_cnt   <= '0;
            in_addr <= '0;
            w_addr  <= w_addr + 16'h1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fc_output_layer.sv
// tb/tb_fc_output_layer.sv - self-checking bench for fc_output_layer
module tb_fc_output_layer;

  localparam int NI = 4;
  localparam int NO = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] rd_addr = '0;

  logic [15:0] in_addr0, w_addr0, in_addr1, w_addr1;
  logic [3:0]  b_addr0, b_addr1;
  logic [7:0]  in_data0, w_data0, in_data1, w_data1;
  logic [31:0] b_data0, b_data1;
  logic [31:0] rd_data0, rd_data1;
  logic [15:0] out_size0, out_size1;
  logic        busy0, done0, busy1, done1;

  logic signed [7:0]  x_mem [NI];
  logic signed [7:0]  w_mem [NI*NO];
  logic signed [31:0] b_mem [NO];

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  fc_output_layer #(.IN_SIZE(NI), .OUT_SIZE(NO), .RELU(0)) dut (
    .clk(clk), .reset(reset), .start(start),
    .in_addr(in_addr0), .in_data(in_data0),
    .w_addr(w_addr0), .w_data(w_data0),
    .b_addr(b_addr0), .b_data(b_data0),
    .rd_addr(rd_addr), .rd_data(rd_data0),
    .out_size(out_size0), .busy(busy0), .done(done0)
  );

  fc_output_layer #(.IN_SIZE(NI), .OUT_SIZE(NO), .RELU(1)) dut_r (
    .clk(clk), .reset(reset), .start(start),
    .in_addr(in_addr1), .in_data(in_data1),
    .w_addr(w_addr1), .w_data(w_data1),
    .b_addr(b_addr1), .b_data(b_data1),
    .rd_addr(rd_addr), .rd_data(rd_data1),
    .out_size(out_size1), .busy(busy1), .done(done1)
  );

  // Synchronous memories with one cycle of read latency.
  always @(posedge clk) begin
    in_data0 <= (in_addr0 < NI) ? x_mem[int'(in_addr0)] : 8'h0;
    w_data0  <= (w_addr0 < NI*NO) ? w_mem[int'(w_addr0)] : 8'h0;
    b_data0  <= (b_addr0 < NO) ? b_mem[int'(b_addr0)] : 32'h0;
    in_data1 <= (in_addr1 < NI) ? x_mem[int'(in_addr1)] : 8'h0;
    w_data1  <= (w_addr1 < NI*NO) ? w_mem[int'(w_addr1)] : 8'h0;
    b_data1  <= (b_addr1 < NO) ? b_mem[int'(b_addr1)] : 32'h0;
  end

  typedef struct {
    string       name;
    logic [31:0] x;
    logic [95:0] w;
    logic [95:0] b;
    logic [95:0] exp_raw;
    logic [95:0] exp_relu;
  } vec_t;

  vec_t vecs [3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic load(input logic [31:0] x, input logic [95:0] w, input logic [95:0] b);
    for (int i = 0; i < NI; i++) x_mem[i] = x[8*i +: 8];
    for (int k = 0; k < NI*NO; k++) w_mem[k] = w[8*k +: 8];
    for (int j = 0; j < NO; j++) b_mem[j] = b[32*j +: 32];
  endtask

  // Reference: exact arithmetic in 64 bits, then the saturate/clamp rules.
  function automatic logic [31:0] ref_logit(input int j, input bit relu);
    longint acc;
    logic [31:0] r;
    acc = longint'(b_mem[j]);
    for (int i = 0; i < NI; i++)
      acc += longint'(x_mem[i]) * longint'(w_mem[j*NI + i]);
    if (acc > 64'sd2147483647) r = 32'h7FFF_FFFF;
    else if (acc < -64'sd2147483648) r = 32'h8000_0000;
    else r = acc[31:0];
    if (relu && r[31]) r = 32'h0;
    return r;
  endfunction

  task automatic check_scores(input string tag, input logic [95:0] e0, input logic [95:0] e1);
    for (int k = 0; k < NO; k++) begin
      rd_addr = 16'(k);
      #1;
      chk($sformatf("%s_score%0d", tag, k), rd_data0, e0[32*k +: 32]);
      chk($sformatf("%s_relu_score%0d", tag, k), rd_data1, e1[32*k +: 32]);
    end
  endtask

  // Pulses start, then follows the run cycle by cycle from the start edge.
  task automatic run(input string tag, input int restart_cyc, input int reset_cyc, input bit poll);
    int cyc;
    int busy_bad;
    int extra_done;
    bit seen;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    cyc = 0; seen = 0; busy_bad = 0;
    if (poll) rd_addr = 16'h0;
    while (!seen && cyc < 40) begin
      @(posedge clk);
      cyc++;
      #1;
      start = (cyc == restart_cyc);
      if (cyc == reset_cyc) begin
        reset = 1'b1;
        #1;
        chk({tag, "_rst_busy"}, {31'h0, busy0}, 32'h0);
        chk({tag, "_rst_done"}, {31'h0, done0}, 32'h0);
        chk({tag, "_rst_waddr"}, {16'h0, w_addr0}, 32'h0);
        check_scores({tag, "_rst"}, 96'h0, 96'h0);
        @(negedge clk) reset = 1'b0;
        return;
      end
      if (poll && cyc == 5) chk({tag, "_poll_c5"}, rd_data0, 32'd0);
      if (poll && cyc == 6) chk({tag, "_poll_c6"}, rd_data0, 32'd20);
      if (done0) seen = 1;
      else if (!busy0) busy_bad++;
    end
    chk({tag, "_done_latency"}, cyc, 32'd18);
    chk({tag, "_relu_done_sync"}, {31'h0, done1}, {31'h0, done0});
    chk({tag, "_busy_span"}, busy_bad, 32'd0);
    chk({tag, "_busy_low_at_done"}, {31'h0, busy0}, 32'h0);
    @(posedge clk);
    #1;
    chk({tag, "_done_width"}, {31'h0, done0}, 32'h0);
    if (restart_cyc > 0) begin
      extra_done = 0;
      for (int c = 0; c < 20; c++) begin
        @(posedge clk);
        #1;
        if (done0) extra_done++;
      end
      chk({tag, "_no_second_done"}, extra_done, 32'd0);
    end
  endtask

  logic [95:0] e0, e1;

  initial begin
    vecs[0] = '{"basic",
                {8'd4, 8'd3, 8'd2, 8'd1},
                {8'd2, 8'd2, 8'd2, 8'd2, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h01, 8'h01, 8'h01, 8'h01},
                {32'hFFFF_FFFB, 32'h0, 32'd10},
                {32'd15, 32'hFFFF_FFFF, 32'd20},
                {32'd15, 32'h0, 32'd20}};
    vecs[1] = '{"sat_pos",
                {4{8'h80}},
                {64'h0, {4{8'h80}}},
                {32'h0, 32'h0, 32'h7FFF_F000},
                {32'h0, 32'h0, 32'h7FFF_FFFF},
                {32'h0, 32'h0, 32'h7FFF_FFFF}};
    vecs[2] = '{"sat_neg",
                {4{8'h7F}},
                {32'h0, {4{8'h80}}, 32'h0},
                {32'h0, 32'h8000_0000, 32'h0},
                {32'h0, 32'h8000_0000, 32'h0},
                96'h0};

    load(vecs[0].x, vecs[0].w, vecs[0].b);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", {31'h0, busy0}, 32'h0);
    chk("reset_done", {31'h0, done0}, 32'h0);
    chk("reset_in_addr", {16'h0, in_addr0}, 32'h0);
    chk("reset_w_addr", {16'h0, w_addr0}, 32'h0);
    chk("reset_b_addr", {28'h0, b_addr0}, 32'h0);
    chk("out_size", {16'h0, out_size0}, 32'd3);
    check_scores("reset", 96'h0, 96'h0);
    @(negedge clk) reset = 1'b0;

    for (int v = 0; v < 3; v++) begin
      load(vecs[v].x, vecs[v].w, vecs[v].b);
      run(vecs[v].name, 0, 0, 0);
      check_scores(vecs[v].name, vecs[v].exp_raw, vecs[v].exp_relu);
    end

    rd_addr = 16'd3;
    #1 chk("rd_oob_3", rd_data0, 32'h0);
    rd_addr = 16'hFFFF;
    #1 chk("rd_oob_ffff", rd_data0, 32'h0);

    load(vecs[0].x, vecs[0].w, vecs[0].b);
    run("restart", 5, 0, 0);
    check_scores("restart", vecs[0].exp_raw, vecs[0].exp_relu);

    run("midreset", 0, 7, 0);
    run("after_reset", 0, 0, 1);
    check_scores("after_reset", vecs[0].exp_raw, vecs[0].exp_relu);

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < NI; i++) x_mem[i] = 8'($urandom);
      for (int k = 0; k < NI*NO; k++) w_mem[k] = 8'($urandom);
      for (int j = 0; j < NO; j++)
        b_mem[j] = (r % 2 == 0) ? 32'($urandom) : 32'($signed(16'($urandom)));
      for (int j = 0; j < NO; j++) begin
        e0[32*j +: 32] = ref_logit(j, 1'b0);
        e1[32*j +: 32] = ref_logit(j, 1'b1);
      end
      run($sformatf("rand%0d", r), 0, 0, 0);
      check_scores($sformatf("rand%0d", r), e0, e1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
